// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared constants, index-mode enum and counter-init helper for
//               the branch direction predictor.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

  localparam int c_pc_bits     = 32;
  localparam int c_idx_bits    = 6;
  localparam int c_ghr_bits    = 6;
  localparam int c_ctr_bits    = 2;
  localparam int c_use_gshare  = 1;

  // How the PHT index is formed from the branch PC.
  typedef enum logic {
    BIMODAL = 1'b0,
    GSHARE  = 1'b1
  } idx_mode_e;

  // Weakly-not-taken value for a counter of the given width: 2^(n-1)-1.
  function automatic logic [3:0] ctr_init(input int ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction

endpackage : bp_pkg
`default_nettype wire

// File: rtl/bp_pht.sv
`default_nettype none
// ============================================================================
// Module      : bp_pht
// Description : Pattern history table of saturating counters with one
//               combinational read port and one read/modify/write port.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_pht
  import bp_pkg::*;
#(
  parameter int IDX_BITS = c_idx_bits,
  parameter int CTR_BITS = c_ctr_bits
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [CTR_BITS-1:0] o_rd_ctr,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic                i_wr_taken
);

  localparam int                  c_entries = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] c_init    = CTR_BITS'(ctr_init(CTR_BITS));
  localparam logic [CTR_BITS-1:0] c_max     = '1;

  logic [CTR_BITS-1:0] r_pht [c_entries];
  logic [CTR_BITS-1:0] w_wr_cur;
  logic [CTR_BITS-1:0] w_wr_nxt;

  // Reads see the table as it stands before this cycle's write lands, so a
  // same-index predict/update pair predicts from the old counter.
  assign o_rd_ctr = r_pht[i_rd_idx];
  assign w_wr_cur = r_pht[i_wr_idx];

  // Saturating step toward the resolved direction.
  always_comb begin
    w_wr_nxt = w_wr_cur;
    if (i_wr_taken && (w_wr_cur != c_max)) begin
      w_wr_nxt = w_wr_cur + CTR_BITS'(1);
    end else if (!i_wr_taken && (w_wr_cur != '0)) begin
      w_wr_nxt = w_wr_cur - CTR_BITS'(1);
    end
  end

  // Counter storage: reset to weakly-not-taken, train one entry per update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_entries; i++) begin
        r_pht[i] <= c_init;
      end
    end else if (i_wr_en) begin
      r_pht[i_wr_idx] <= w_wr_nxt;
    end
  end

endmodule : bp_pht
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare / bimodal branch direction predictor with global
//               history register, registered prediction outputs and
//               saturating prediction / misprediction statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int PC_BITS    = c_pc_bits,
  parameter int IDX_BITS   = c_idx_bits,
  parameter int GHR_BITS   = c_ghr_bits,
  parameter int CTR_BITS   = c_ctr_bits,
  parameter int USE_GSHARE = c_use_gshare
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pred_valid_i,
  input  logic [PC_BITS-1:0]  pred_pc_i,
  output logic                pred_valid_o,
  output logic                pred_taken_o,
  output logic [IDX_BITS-1:0] pred_idx_o,
  input  logic                upd_valid_i,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_taken_i,
  input  logic                upd_mispredict_i,
  output logic [GHR_BITS-1:0] ghr_o,
  output logic [31:0]         stat_pred_o,
  output logic [31:0]         stat_mispred_o
);

  localparam idx_mode_e c_mode = (USE_GSHARE != 0) ? GSHARE : BIMODAL;

  logic [GHR_BITS-1:0] r_ghr;
  logic [IDX_BITS-1:0] w_pc_idx;
  logic [IDX_BITS-1:0] w_idx;
  logic [CTR_BITS-1:0] w_ctr;
  logic                r_pred_valid;
  logic                r_pred_taken;
  logic [IDX_BITS-1:0] r_pred_idx;
  logic [31:0]         r_stat_pred;
  logic [31:0]         r_stat_mispred;
  logic                w_unused;

  // Branches are word aligned, so PC bits [1:0] carry no information.
  assign w_pc_idx = pred_pc_i[IDX_BITS+1:2];

  generate
    if (c_mode == GSHARE) begin : g_gshare
      // History occupies the low index bits; shorter histories zero-extend.
      assign w_idx = w_pc_idx ^ IDX_BITS'(r_ghr);
    end else begin : g_bimodal
      assign w_idx = w_pc_idx;
    end
  endgenerate

  bp_pht #(
    .IDX_BITS (IDX_BITS),
    .CTR_BITS (CTR_BITS)
  ) u_pht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rd_idx   (w_idx),
    .o_rd_ctr   (w_ctr),
    .i_wr_en    (upd_valid_i),
    .i_wr_idx   (upd_idx_i),
    .i_wr_taken (upd_taken_i)
  );

  // Only the counter MSB and the index PC bits feed the prediction.
  assign w_unused = ^{pred_pc_i, w_ctr};

  // Global history: shift in each resolved direction, oldest bit falls off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= '0;
    end else if (upd_valid_i) begin
      r_ghr <= GHR_BITS'({r_ghr, upd_taken_i});
    end
  end

  // Prediction result register: valid pulses per request, payload holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_idx   <= '0;
    end else begin
      r_pred_valid <= pred_valid_i;
      if (pred_valid_i) begin
        r_pred_taken <= w_ctr[CTR_BITS-1];
        r_pred_idx   <= w_idx;
      end
    end
  end

  // Saturating event counters for issued predictions and reported misses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pred    <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (pred_valid_i && (r_stat_pred != 32'hFFFF_FFFF)) begin
        r_stat_pred <= r_stat_pred + 32'd1;
      end
      if (upd_valid_i && upd_mispredict_i && (r_stat_mispred != 32'hFFFF_FFFF)) begin
        r_stat_mispred <= r_stat_mispred + 32'd1;
      end
    end
  end

  assign pred_valid_o   = r_pred_valid;
  assign pred_taken_o   = r_pred_taken;
  assign pred_idx_o     = r_pred_idx;
  assign ghr_o          = r_ghr;
  assign stat_pred_o    = r_stat_pred;
  assign stat_mispred_o = r_stat_mispred;

endmodule : gshare_predictor
`default_nettype wire
